// File: rtl/hq2x_pkg.sv
// Shared types and helpers for the hq2x line buffer and its line sequencer.
package hq2x_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRep0,
        StRep1
    } rd_state_e;

    // MSB index of a line buffer address able to hold `length` entries (capped at 10).
    function automatic int unsigned hq2x_awidth(input int unsigned length);
        int unsigned aw;
        aw = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            if ((32'd2 << i) < length) begin
                aw = i + 1;
            end
        end
        return aw;
    endfunction

endpackage

// File: rtl/hq2x_line_ctl_if.sv
// Video strobes in, line buffer write/read control out, for hq2x_line_ctl.
interface hq2x_line_ctl_if
    import hq2x_pkg::*;
#(
    parameter int unsigned LENGTH = 256
);

    localparam int unsigned AWIDTH = hq2x_awidth(LENGTH);

    logic              ce_in;
    logic              hblank;
    logic              vblank;
    logic              ce_out;
    logic [AWIDTH:0]   wraddr;
    logic              wrbuf;
    logic              wren;
    logic [AWIDTH:0]   rdaddr;
    logic              rdbuf;
    logic              rd_valid;
    logic              rd_phase;
    logic              line_start;
    logic              overrun;

    modport master (
        input  ce_in, hblank, vblank, ce_out,
        output wraddr, wrbuf, wren, rdaddr, rdbuf, rd_valid, rd_phase, line_start, overrun
    );

    modport slave (
        output ce_in, hblank, vblank, ce_out,
        input  wraddr, wrbuf, wren, rdaddr, rdbuf, rd_valid, rd_phase, line_start, overrun
    );

endinterface

// File: rtl/hq2x_line_wrseq.sv
// Write side of the hq2x line sequencer: active pixel counter, hblank edge
// detect, buffer swap and completed-line length latch.
module hq2x_line_wrseq
    import hq2x_pkg::*;
#(
    parameter int unsigned LENGTH = 256,
    parameter int unsigned AWIDTH = hq2x_awidth(LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_in,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              take,
    output logic [AWIDTH:0]   wraddr,
    output logic              wren,
    output logic              wrbuf,
    output logic              swap,
    output logic              ready,
    output logic [AWIDTH+1:0] len
);

    // One bit wider than the address so a full line of LENGTH pixels is representable.
    localparam int unsigned CW = AWIDTH + 2;
    localparam logic [CW-1:0] FULL = CW'(LENGTH);

    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          hblank_q;
    logic          wrbuf_q, wrbuf_d;
    logic          ready_q, ready_d;

    assign wren   = ce_in & ~hblank & ~vblank & (wcnt_q < FULL);
    assign wraddr = wcnt_q[AWIDTH:0];
    assign swap   = hblank & ~hblank_q & ~vblank & (wcnt_q != '0);

    assign wrbuf = wrbuf_q;
    assign ready = ready_q;
    assign len   = len_q;

    always_comb begin
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        wrbuf_d = wrbuf_q;
        // A swap in the same cycle as the reader's take re-arms ready.
        ready_d = ready_q & ~take;
        if (vblank) begin
            wcnt_d = '0;
        end else if (swap) begin
            len_d   = wcnt_q;
            wrbuf_d = ~wrbuf_q;
            wcnt_d  = '0;
            ready_d = 1'b1;
        end else if (wren) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q   <= '0;
            len_q    <= '0;
            hblank_q <= 1'b0;
            wrbuf_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            len_q    <= len_d;
            hblank_q <= hblank;
            wrbuf_q  <= wrbuf_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: rtl/hq2x_line_ctl.sv
// hq2x ping-pong line buffer sequencer: writes each input line, then replays it
// twice on the read side. HQ2X_LINE_CTL_OVERRUN_EN builds the sticky overrun flag.
module hq2x_line_ctl
    import hq2x_pkg::*;
#(
    parameter int unsigned LENGTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    hq2x_line_ctl_if.master bus
);

    localparam int unsigned AWIDTH = hq2x_awidth(LENGTH);
    localparam int unsigned CW     = AWIDTH + 2;

    logic [AWIDTH:0] wraddr;
    logic            wren;
    logic            wrbuf;
    logic            swap;
    logic            ready;
    logic [CW-1:0]   len;
    logic            take;

    hq2x_line_wrseq #(
        .LENGTH (LENGTH),
        .AWIDTH (AWIDTH)
    ) u_wrseq (
        .clk    (clk),
        .reset  (reset),
        .ce_in  (bus.ce_in),
        .hblank (bus.hblank),
        .vblank (bus.vblank),
        .take   (take),
        .wraddr (wraddr),
        .wren   (wren),
        .wrbuf  (wrbuf),
        .swap   (swap),
        .ready  (ready),
        .len    (len)
    );

    rd_state_e       state_q, state_d;
    logic [AWIDTH:0] rcnt_q, rcnt_d;
    logic [CW-1:0]   rlen_q, rlen_d;
    logic            rdbuf_q, rdbuf_d;
    logic            line_start_q, line_start_d;
    logic            rd_valid_q, rd_valid_d;
    logic            last;

    assign last = ({1'b0, rcnt_q} == rlen_q - 1'b1);

    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        rlen_d       = rlen_q;
        rdbuf_d      = rdbuf_q;
        line_start_d = 1'b0;
        take         = 1'b0;
        rd_valid_d   = bus.ce_out & (state_q != StIdle);
        case (state_q)
            StIdle: begin
                if (ready) begin
                    // Pre-toggle wrbuf: the completed buffer even if a swap lands now.
                    take         = 1'b1;
                    state_d      = StRep0;
                    rdbuf_d      = ~wrbuf;
                    rlen_d       = len;
                    rcnt_d       = '0;
                    line_start_d = 1'b1;
                end
            end
            StRep0: begin
                if (bus.ce_out) begin
                    if (last) begin
                        state_d      = StRep1;
                        rcnt_d       = '0;
                        line_start_d = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            StRep1: begin
                if (bus.ce_out) begin
                    if (last) begin
                        rcnt_d = '0;
                        if (ready) begin
                            take         = 1'b1;
                            state_d      = StRep0;
                            rdbuf_d      = ~wrbuf;
                            rlen_d       = len;
                            line_start_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rcnt_q       <= '0;
            rlen_q       <= '0;
            rdbuf_q      <= 1'b1;
            line_start_q <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            rlen_q       <= rlen_d;
            rdbuf_q      <= rdbuf_d;
            line_start_q <= line_start_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

`ifdef HQ2X_LINE_CTL_OVERRUN_EN
    logic overrun_q;

    // A second completed line while one is still queued will land on the buffer being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (swap && ready && (state_q != StIdle)) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`else
    logic unused_swap;
    assign unused_swap = swap;
    assign bus.overrun = 1'b0;
`endif

    assign bus.wraddr     = wraddr;
    assign bus.wren       = wren;
    assign bus.wrbuf      = wrbuf;
    assign bus.rdaddr     = rcnt_q;
    assign bus.rdbuf      = rdbuf_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_phase   = (state_q == StRep1);
    assign bus.line_start = line_start_q;

endmodule

// File: tb/tb_hq2x_line_ctl.sv
// Bench for hq2x_line_ctl at LENGTH=8; overrun expectations follow HQ2X_LINE_CTL_OVERRUN_EN.
module tb_hq2x_line_ctl;

    localparam int unsigned LEN = 8;

`ifdef HQ2X_LINE_CTL_OVERRUN_EN
    localparam logic OVR_EN = 1'b1;
`else
    localparam logic OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    hq2x_line_ctl_if #(.LENGTH(LEN)) bus ();

    hq2x_line_ctl #(.LENGTH(LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ci, hb, vb, co;
        logic       wren;
        logic [2:0] wa;
        logic       wb;
        logic [2:0] ra;
        logic       rb, rv, ph, ls;
    } vec_t;

    typedef struct {
        logic b;
        int   a;
        logic p;
    } rd_t;

    vec_t vecs [28];
    rd_t  rd_q [$];

    int   m_cnt;
    logic m_wrbuf, m_hbp;
    int   exp_ls, got_ls;
    logic [2:0] p_a;
    logic p_b, p_ph;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ci, input logic hb, input logic vb, input logic co);
        bus.ce_in  = ci;
        bus.hblank = hb;
        bus.vblank = vb;
        bus.ce_out = co;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " wraddr"}, bus.wraddr, 0);
        chk({tag, " wrbuf"}, bus.wrbuf, 0);
        chk({tag, " wren"}, bus.wren, 0);
        chk({tag, " rdaddr"}, bus.rdaddr, 0);
        chk({tag, " rdbuf"}, bus.rdbuf, 1);
        chk({tag, " rd_valid"}, bus.rd_valid, 0);
        chk({tag, " rd_phase"}, bus.rd_phase, 0);
        chk({tag, " line_start"}, bus.line_start, 0);
        chk({tag, " overrun"}, bus.overrun, 0);
    endtask

    function automatic vec_t mk(input logic ci, input logic hb, input logic vb, input logic co,
                                input logic wren, input logic [2:0] wa, input logic wb,
                                input logic [2:0] ra, input logic rb, input logic rv,
                                input logic ph, input logic ls);
        vec_t v;
        v.ci = ci; v.hb = hb; v.vb = vb; v.co = co;
        v.wren = wren; v.wa = wa; v.wb = wb;
        v.ra = ra; v.rb = rb; v.rv = rv; v.ph = ph; v.ls = ls;
        return v;
    endfunction

    // Random-phase cycle: spec-level write model plus a queue of expected replay reads.
    task automatic rcycle(input logic ci, input logic hb, input logic vb, input logic co);
        logic exp_wren;
        rd_t  it;
        set_in(ci, hb, vb, co);
        @(negedge clk);
        exp_wren = ci && !hb && !vb && (m_cnt < LEN);
        chk("rnd wren", bus.wren, exp_wren);
        if (exp_wren) chk("rnd wraddr", bus.wraddr, m_cnt);
        chk("rnd wrbuf", bus.wrbuf, m_wrbuf);
        if (bus.line_start) got_ls++;
        if (bus.rd_valid) begin
            if (rd_q.size() == 0) begin
                chk("rnd unexpected rd_valid", bus.rd_valid, 0);
            end else begin
                it = rd_q.pop_front();
                chk("rnd rdaddr", p_a, it.a);
                chk("rnd rdbuf", p_b, it.b);
                chk("rnd rd_phase", p_ph, it.p);
            end
        end
        p_a  = bus.rdaddr;
        p_b  = bus.rdbuf;
        p_ph = bus.rd_phase;
        if (vb) begin
            m_cnt = 0;
        end else if (hb && !m_hbp && m_cnt != 0) begin
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < m_cnt; a++) rd_q.push_back('{b: m_wrbuf, a: a, p: p[0]});
            exp_ls += 2;
            m_wrbuf = !m_wrbuf;
            m_cnt = 0;
        end else if (exp_wren) begin
            m_cnt++;
        end
        m_hbp = hb;
        next();
    endtask

    initial begin
        int   nrd, nls, found, at;
        logic [2:0] ta [64];
        logic tb_buf [64], tph [64], tls [64], trv [64];

        // Basic doubling (5 px), then zero-length hblank and vblank mid-line.
        vecs[0] = mk(1,0,0,1, 1,3'd0,0, 3'd0,1,0,0,0);
        for (int i = 1; i < 5; i++) vecs[i] = mk(1,0,0,1, 1,3'(i),0, 3'd0,1,0,0,0);
        vecs[5] = mk(0,1,0,1, 0,3'd5,0, 3'd0,1,0,0,0);
        vecs[6] = mk(0,1,0,1, 0,3'd0,1, 3'd0,1,0,0,0);
        vecs[7] = mk(0,1,0,1, 0,3'd0,1, 3'd0,0,0,0,1);
        for (int i = 8; i < 12; i++) vecs[i] = mk(0,1,0,1, 0,3'd0,1, 3'(i-7),0,1,0,0);
        for (int i = 12; i < 17; i++) vecs[i] = mk(0,1,0,1, 0,3'd0,1, 3'(i-12),0,1,1,i==12);
        vecs[17] = mk(0,1,0,1, 0,3'd0,1, 3'd0,0,1,0,0);
        vecs[18] = mk(0,1,0,1, 0,3'd0,1, 3'd0,0,0,0,0);
        vecs[19] = mk(0,0,0,1, 0,3'd0,1, 3'd0,0,0,0,0);
        vecs[20] = mk(0,1,0,1, 0,3'd0,1, 3'd0,0,0,0,0);
        vecs[21] = mk(0,1,0,1, 0,3'd0,1, 3'd0,0,0,0,0);
        for (int i = 22; i < 25; i++) vecs[i] = mk(1,0,0,1, 1,3'(i-22),1, 3'd0,0,0,0,0);
        vecs[25] = mk(1,0,1,1, 0,3'd3,1, 3'd0,0,0,0,0);
        vecs[26] = mk(0,1,0,1, 0,3'd0,1, 3'd0,0,0,0,0);
        vecs[27] = mk(0,1,0,1, 0,3'd0,1, 3'd0,0,0,0,0);

        do_reset();
        @(negedge clk);
        chk_reset_vals("reset");
        next();

        foreach (vecs[i]) begin
            set_in(vecs[i].ci, vecs[i].hb, vecs[i].vb, vecs[i].co);
            @(negedge clk);
            chk($sformatf("vec%0d wren", i), bus.wren, vecs[i].wren);
            chk($sformatf("vec%0d wraddr", i), bus.wraddr, vecs[i].wa);
            chk($sformatf("vec%0d wrbuf", i), bus.wrbuf, vecs[i].wb);
            chk($sformatf("vec%0d rdaddr", i), bus.rdaddr, vecs[i].ra);
            chk($sformatf("vec%0d rdbuf", i), bus.rdbuf, vecs[i].rb);
            chk($sformatf("vec%0d rd_valid", i), bus.rd_valid, vecs[i].rv);
            chk($sformatf("vec%0d rd_phase", i), bus.rd_phase, vecs[i].ph);
            chk($sformatf("vec%0d line_start", i), bus.line_start, vecs[i].ls);
            chk($sformatf("vec%0d overrun", i), bus.overrun, 0);
            next();
        end

        // Saturation: 12 pixels into an 8-deep line.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(1, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("sat wren px%0d", i), bus.wren, (i < LEN));
            if (i < LEN) chk($sformatf("sat wraddr px%0d", i), bus.wraddr, i);
            next();
        end
        nrd = 0;
        nls = 0;
        for (int c = 0; c < 40; c++) begin
            set_in(0, 1, 0, 1);
            @(negedge clk);
            if (bus.rd_valid) nrd++;
            if (bus.line_start) nls++;
            next();
        end
        chk("sat replay reads", nrd, 16);
        chk("sat line_start pulses", nls, 2);

        // Back-to-back: 4-pixel then 6-pixel line, ce_out every cycle.
        do_reset();
        for (int c = 0; c < 64; c++) begin
            set_in((c < 4) || (c >= 6 && c < 12), (c == 4) || (c == 5) || (c >= 12), 0, 1);
            @(negedge clk);
            ta[c] = bus.rdaddr;
            tb_buf[c] = bus.rdbuf;
            tph[c] = bus.rd_phase;
            tls[c] = bus.line_start;
            trv[c] = bus.rd_valid;
            next();
        end
        found = 0;
        at = 0;
        nrd = 0;
        for (int c = 1; c < 64; c++) begin
            if (trv[c]) nrd++;
            if (found == 0 && tls[c] && tb_buf[c]) begin
                found = 1;
                at = c;
            end
        end
        chk("b2b line2 start seen", found, 1);
        chk("b2b line2 start cycle", at, 14);
        if (found != 0) begin
            chk("b2b prev rdaddr", ta[at-1], 3);
            chk("b2b prev rd_phase", tph[at-1], 1);
            chk("b2b prev rdbuf", tb_buf[at-1], 0);
            chk("b2b line2 rd_phase", tph[at], 0);
            chk("b2b line2 rdaddr", ta[at], 0);
        end
        chk("b2b total reads", nrd, 20);

        // Overrun: three 8-pixel lines, ce_out every 4th cycle.
        do_reset();
        for (int c = 0; c < 120; c++) begin
            set_in((c < 30) && ((c % 10) < 8), !((c < 30) && ((c % 10) < 8)), 0, (c % 4) == 0);
            @(negedge clk);
            if (c == 19) chk("ovr after 2nd swap", bus.overrun, 0);
            if (c == 28) chk("ovr before 3rd swap", bus.overrun, 0);
            if (c == 29) chk("ovr at 3rd swap", bus.overrun, OVR_EN);
            if (c == 119) chk("ovr sticky", bus.overrun, OVR_EN);
            next();
        end

        // Reset in REP0 at rdaddr 3.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 0, 1);
            next();
        end
        set_in(0, 1, 0, 1);
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk);
            if (bus.rdaddr == 3 && !bus.rd_phase && bus.rd_valid) found = 1;
            else next();
        end
        chk("rst rep0 addr3 reached", found, 1);
        reset = 1'b1;
        next();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst after");
        next();
        nrd = 0;
        nls = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rd_valid) nrd++;
            if (bus.line_start) nls++;
            next();
        end
        chk("rst idle reads", nrd, 0);
        chk("rst idle line_start", nls, 0);

        // Randomized lines against the queue model.
        do_reset();
        m_cnt = 0; m_wrbuf = 1'b0; m_hbp = 1'b0;
        exp_ls = 0; got_ls = 0;
        p_a = '0; p_b = 1'b1; p_ph = 1'b0;
        rd_q.delete();
        for (int ln = 0; ln < 40; ln++) begin
            int act;
            int vpos;
            act = int'($urandom_range(0, 14));
            vpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 14)) : -1;
            for (int c = 0; c < act; c++)
                rcycle($urandom_range(0, 3) != 0, 0, c == vpos, $urandom_range(0, 3) != 0);
            for (int c = 0; c < 60; c++)
                rcycle($urandom_range(0, 1) != 0, 1, 0, $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 80 && rd_q.size() != 0; c++) rcycle(0, 1, 0, 1);
        chk("rnd reads drained", rd_q.size(), 0);
        chk("rnd line_start pulses", got_ls, exp_ls);
        chk("rnd no overrun", bus.overrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
